bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/bus_sequencer.sv | 118 +++++++++++
 tb/tb_bus_sequencer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sequencer_pkg.sv
// rtl/bus_sequencer_pkg.sv - shared sizing defaults and FSM encoding for bus_sequencer
package bus_sequencer_pkg;

  localparam int NUM_REGS_DEF = 8;
  localparam int NUM_REQ_DEF  = 4;
  localparam int SEL_W_DEF    = $clog2(NUM_REGS_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index width that stays at least one bit for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer position
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int  cand;
    logic found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr_i) + k) % N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IDX_W'(cand);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - arbitrates register-to-register bus transfers through a 4-phase FSM
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int SEL_W    = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*SEL_W-1:0]    req_src,
  input  logic [NUM_REQ*NUM_REGS-1:0] req_dst,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic [NUM_REGS-1:0]         reg_enable,
  output logic [NUM_REGS-1:0]         reg_latch,
  output logic                        busy
);

  localparam int REQ_W = idx_width(NUM_REQ);

  state_t              state_q;
  logic [REQ_W-1:0]    ptr_q;
  logic [REQ_W-1:0]    win_q;
  logic [SEL_W-1:0]    src_q;
  logic [NUM_REGS-1:0] dst_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  done_q;
  logic [NUM_REGS-1:0] enable_q;
  logic [NUM_REGS-1:0] latch_q;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [REQ_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [SEL_W-1:0]    src_d;
  logic [NUM_REGS-1:0] dst_d;
  logic [REQ_W-1:0]    ptr_d;

  function automatic logic [NUM_REGS-1:0] reg_bit(input logic [SEL_W-1:0] s);
    reg_bit    = '0;
    reg_bit[s] = 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] req_bit(input logic [REQ_W-1:0] w);
    req_bit    = '0;
    req_bit[w] = 1'b1;
  endfunction

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (REQ_W)
  ) u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    src_d = req_src[int'(arb_idx)*SEL_W +: SEL_W];
    dst_d = req_dst[int'(arb_idx)*NUM_REGS +: NUM_REGS];
    ptr_d = (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 1'b1;
  end

  // The DONE cycle leaves the bus undriven before the next DRIVE can begin.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      enable_q <= '0;
      latch_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q  <= ST_DRIVE;
            win_q    <= arb_idx;
            src_q    <= src_d;
            dst_q    <= dst_d;
            ptr_q    <= ptr_d;
            grant_q  <= arb_grant;
            enable_q <= reg_bit(src_d);
          end
        end
        ST_DRIVE: begin
          state_q <= ST_LATCH;
          grant_q <= '0;
          latch_q <= dst_q & ~reg_bit(src_q);
        end
        ST_LATCH: begin
          state_q  <= ST_DONE;
          enable_q <= '0;
          latch_q  <= '0;
          done_q   <= req_bit(win_q);
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant      = grant_q;
  assign done       = done_q;
  assign reg_enable = enable_q;
  assign reg_latch  = latch_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - transaction-level model and directed checks for bus_sequencer
module tb_bus_sequencer;

  localparam int NREGS = 8;
  localparam int NR    = 4;
  localparam int SW    = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req = '0;
  logic [NR*SW-1:0]  req_src = '0;
  logic [NR*NREGS-1:0] req_dst = '0;
  logic [NR-1:0]     grant;
  logic [NR-1:0]     done;
  logic [NREGS-1:0]  reg_enable;
  logic [NREGS-1:0]  reg_latch;
  logic              busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_sequencer #(
    .NUM_REGS (NREGS),
    .NUM_REQ  (NR),
    .SEL_W    (SW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_src    (req_src),
    .req_dst    (req_dst),
    .grant      (grant),
    .done       (done),
    .reg_enable (reg_enable),
    .reg_latch  (reg_latch),
    .busy       (busy)
  );

  // Register file sitting on the shared 16-bit bus
  logic [15:0] regs [NREGS];
  logic [15:0] bus;
  logic        ld_en = 1'b0;
  int          ld_idx = 0;
  logic [15:0] ld_val = '0;

  always_comb begin
    bus = '0;
    for (int i = 0; i < NREGS; i++)
      if (reg_enable[i]) bus = bus | regs[i];
  end

  always @(posedge clk) begin
    if (ld_en) regs[ld_idx] <= ld_val;
    for (int i = 0; i < NREGS; i++)
      if (reg_latch[i]) regs[i] <= bus;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transfer model: a request accepted in an idle cycle t schedules its three output cycles.
  int cyc = 0;
  int m_ptr = 0;
  int m_free = 0;
  logic [NR-1:0]    e_grant [8];
  logic [NR-1:0]    e_done  [8];
  logic [NREGS-1:0] e_en    [8];
  logic [NREGS-1:0] e_latch [8];
  logic             e_busy  [8];

  always @(posedge clk) begin
    int t, w, c;
    logic [SW-1:0]    src;
    logic [NREGS-1:0] dst, sb;
    t = cyc;
    if (reset) begin
      for (int s = 0; s < 8; s++) begin
        e_grant[s] = '0; e_done[s] = '0; e_en[s] = '0; e_latch[s] = '0; e_busy[s] = 1'b0;
      end
      m_ptr  = 0;
      m_free = t + 1;
    end else if (t >= m_free && req != '0) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (w < 0 && req[c]) w = c;
      end
      src = req_src[w*SW +: SW];
      dst = req_dst[w*NREGS +: NREGS];
      sb  = NREGS'(1) << src;
      e_grant[(t+1)%8] = NR'(1) << w;
      e_en[(t+1)%8]    = sb;
      e_busy[(t+1)%8]  = 1'b1;
      e_en[(t+2)%8]    = sb;
      e_latch[(t+2)%8] = dst & ~sb;
      e_busy[(t+2)%8]  = 1'b1;
      e_done[(t+3)%8]  = NR'(1) << w;
      e_busy[(t+3)%8]  = 1'b1;
      m_ptr  = (w + 1) % NR;
      m_free = t + 4;
    end
    cyc = t + 1;
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    int s;
    if (chk_en) begin
      s = cyc % 8;
      chk("grant", 32'(grant), 32'(e_grant[s]));
      chk("done", 32'(done), 32'(e_done[s]));
      chk("reg_enable", 32'(reg_enable), 32'(e_en[s]));
      chk("reg_latch", 32'(reg_latch), 32'(e_latch[s]));
      chk("busy", 32'(busy), 32'(e_busy[s]));
      chk("enable_onehot", 32'($countones(reg_enable) <= 1), 32'd1);
      if (reg_enable != '0) chk("bus_known", 32'($isunknown(bus)), 32'd0);
      e_grant[s] = '0; e_done[s] = '0; e_en[s] = '0; e_latch[s] = '0; e_busy[s] = 1'b0;
    end
  end

  logic rec_en = 1'b0;
  logic [NR-1:0] gq [$];

  always @(negedge clk)
    if (rec_en && grant != '0) gq.push_back(grant);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [15:0] v);
    ld_en = 1'b1; ld_idx = idx; ld_val = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic set_req(input int i, input int src, input logic [7:0] dst);
    req_src[i*SW +: SW]       = SW'(src);
    req_dst[i*NREGS +: NREGS] = dst;
  endtask

  task automatic wait_idle(input int maxc);
    int n;
    n = 0;
    while (busy && n < maxc) begin
      tick();
      n++;
    end
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cdst [4];
    cdst[0] = 8'h10; cdst[1] = 8'h20; cdst[2] = 8'h0C; cdst[3] = 8'h81;

    reset = 1'b1;
    tick(); tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_enable", 32'(reg_enable), 32'd0);
    chk("rst_latch", 32'(reg_latch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Single transfer R2 -> R4
    load(4, 16'h0000);
    load(2, 16'hBEEF);
    set_req(0, 2, 8'h10);
    req = 4'b0001;
    tick();
    req = '0;
    chk("single_grant", 32'(grant), 32'h1);
    chk("single_en_c1", 32'(reg_enable), 32'h04);
    tick();
    chk("single_en_c2", 32'(reg_enable), 32'h04);
    chk("single_latch", 32'(reg_latch), 32'h10);
    tick();
    chk("single_done", 32'(done), 32'h1);
    tick();
    chk("single_r4", 32'(regs[4]), 32'hBEEF);
    chk("single_idle", 32'(busy), 32'd0);

    // One-cycle request pulse still completes, no second grant
    set_req(2, 0, 8'h02);
    req = 4'b0100;
    tick();
    req = '0;
    chk("withdraw_grant", 32'(grant), 32'h4);
    tick(); tick();
    chk("withdraw_done", 32'(done), 32'h4);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("withdraw_nogrant", 32'(grant), 32'd0);
    end

    // Destination mask equal to the source bit only
    set_req(1, 5, 8'h20);
    req = 4'b0010;
    tick();
    req = '0;
    chk("selfmask_latch_c1", 32'(reg_latch), 32'd0);
    tick();
    chk("selfmask_latch_c2", 32'(reg_latch), 32'd0);
    tick();
    chk("selfmask_latch_c3", 32'(reg_latch), 32'd0);
    chk("selfmask_done", 32'(done), 32'h2);
    tick();

    // Broadcast R1 to every other register
    load(1, 16'h1234);
    set_req(3, 1, 8'hFF);
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    chk("bcast_latch", 32'(reg_latch), 32'hFD);
    tick();
    chk("bcast_done", 32'(done), 32'h8);
    tick();
    for (int i = 0; i < NREGS; i++) chk("bcast_reg", 32'(regs[i]), 32'h1234);

    // Reset during LATCH: strobe already out, so R6 captures; nothing afterwards
    load(6, 16'h0000);
    load(3, 16'hA5A5);
    set_req(0, 3, 8'h40);
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    chk("rstlatch_latch", 32'(reg_latch), 32'h40);
    reset = 1'b1;
    tick();
    chk("rstlatch_done", 32'(done), 32'd0);
    chk("rstlatch_busy", 32'(busy), 32'd0);
    chk("rstlatch_enable", 32'(reg_enable), 32'd0);
    reset = 1'b0;
    tick();
    chk("rstlatch_nodone", 32'(done), 32'd0);
    chk("rstlatch_r6", 32'(regs[6]), 32'hA5A5);

    // Reset during DRIVE: aborted before any latch, R6 untouched
    load(6, 16'h0000);
    req = 4'b0001;
    tick();
    req = '0;
    chk("rstdrive_grant", 32'(grant), 32'h1);
    reset = 1'b1;
    tick();
    chk("rstdrive_latch", 32'(reg_latch), 32'd0);
    chk("rstdrive_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("rstdrive_r6", 32'(regs[6]), 32'h0000);

    // All four requesting continuously, pointer starts at 0 after reset
    for (int i = 0; i < NR; i++) set_req(i, i, cdst[i]);
    gq.delete();
    rec_en = 1'b1;
    req = 4'b1111;
    for (int n = 0; n < 48 && gq.size() < 8; n++) tick();
    req = '0;
    rec_en = 1'b0;
    chk("rr_count", 32'(gq.size()), 32'd8);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      chk("rr_order", 32'(gq[i]), 32'(1 << (i % 4)));
    wait_idle(8);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
